// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard detection, forwarding select and memory-wait control.
// Stall/flush/forward outputs are combinational. The RUN/WAIT FSM tracks
// outstanding data-memory accesses and raises a sticky timeout flag.
// Optional macro HAZARD_PERF_EN adds three saturating performance counters.
// Without it, the counter ports read as zero.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic [1:0]  ResultSrcE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        dmem_req_M,
    input  logic        dmem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_timeout,
    output logic [31:0] lw_stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] mem_stall_count
);

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t      r_state;
    logic [15:0] r_wait_cnt;
    logic        r_mem_timeout;

    logic        w_mem_stall;
    logic        w_lw_stall;
    logic        w_in_wait;
    logic [15:0] w_wait_next;

    assign w_mem_stall = dmem_req_M && !dmem_ready;
    assign w_lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_in_wait   = (r_state == WAIT);
    assign mem_timeout = r_mem_timeout;

    // Forward select per operand: M stage wins over W, x0 is never forwarded.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = 2'b01;
        end
    end

    // Stall/flush decisions; a memory wait freezes the pipe and masks branches and load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            if (w_mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                FlushD = PCSrcE;
                FlushE = PCSrcE || w_lw_stall;
                StallF = w_lw_stall && !PCSrcE;
                StallD = w_lw_stall && !PCSrcE;
            end
        end
    end

    // Next wait count: clear on entry to WAIT, count up while the wait persists, saturate.
    always_comb begin
        w_wait_next = r_wait_cnt;
        if (!w_in_wait && w_mem_stall)
            w_wait_next = 16'd0;
        else if (w_in_wait && w_mem_stall && (r_wait_cnt != TIMEOUT_VAL))
            w_wait_next = r_wait_cnt + 16'd1;
    end

    // RUN/WAIT FSM, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN:     if (w_mem_stall)  r_state <= WAIT;
                WAIT:    if (!w_mem_stall) r_state <= RUN;
                default: r_state <= RUN;
            endcase
            r_wait_cnt <= w_wait_next;
            if (w_in_wait && w_mem_stall && (w_wait_next == TIMEOUT_VAL))
                r_mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_lw_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_mem_cnt;

    // Saturating event counters: load-use stalls, decode flushes, memory-wait cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lw_cnt    <= 32'd0;
            r_flush_cnt <= 32'd0;
            r_mem_cnt   <= 32'd0;
        end else begin
            if (!w_mem_stall && w_lw_stall && !PCSrcE && (r_lw_cnt != 32'hFFFF_FFFF))
                r_lw_cnt <= r_lw_cnt + 32'd1;
            if (!w_mem_stall && PCSrcE && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (w_mem_stall && (r_mem_cnt != 32'hFFFF_FFFF))
                r_mem_cnt <= r_mem_cnt + 32'd1;
        end
    end

    assign lw_stall_count  = r_lw_cnt;
    assign flush_count     = r_flush_cnt;
    assign mem_stall_count = r_mem_cnt;
`else
    assign lw_stall_count  = 32'd0;
    assign flush_count     = 32'd0;
    assign mem_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven and directed checks for hazard_unit (MEM_TIMEOUT=4).
// Packed output word: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}.
module tb_hazard_unit;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, dmem_req_M, dmem_ready;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        mem_timeout;
    logic [31:0] lw_stall_count, flush_count, mem_stall_count;

    hazard_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout),
        .lw_stall_count(lw_stall_count), .flush_count(flush_count),
        .mem_stall_count(mem_stall_count)
    );

    wire [10:0] w_outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                          ForwardAE, ForwardBE};

    typedef struct {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0]  rsrc;
        logic        rwm, rww, pcsrc, req, rdy;
        logic [10:0] exp;
    } vec_t;

    // ---------------- scoreboard ----------------
    logic [10:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw; ResultSrcE = v.rsrc;
        RegWriteM = v.rwm; RegWriteW = v.rww; PCSrcE = v.pcsrc;
        dmem_req_M = v.req; dmem_ready = v.rdy;
    endtask

    task automatic check_outs(input string nm, input logic [10:0] exp);
        logic [10:0] e;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check(nm, {21'd0, w_outs}, {21'd0, e});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0};
        return v;
    endfunction

    // Reference model written from the hazard rules.
    function automatic logic [1:0] fwd_model(input vec_t v, input logic [4:0] rs);
        if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
        if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [10:0] model(input vec_t v);
        logic ms, lw;
        logic [6:0] sf;
        ms = v.req && !v.rdy;
        lw = (v.rsrc == 2'b01) && (v.rde != 0) && (v.rde == v.rs1d || v.rde == v.rs2d);
        if (ms) sf = 7'b1111001;
        else sf = {lw && !v.pcsrc, lw && !v.pcsrc, 2'b00, v.pcsrc, v.pcsrc || lw, 1'b0};
        return {sf, fwd_model(v, v.rs1e), fwd_model(v, v.rs2e)};
    endfunction

    vec_t vecs[12];
    vec_t v;

    initial begin
        // fields: rs1d rs2d rs1e rs2e rde rdm rdw rsrc rwm rww pcsrc req rdy exp
        vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 2'b00, 1, 1, 0, 0, 1, 11'b0000000_10_00};
        vecs[1]  = '{0, 0, 5, 0, 0, 5, 5, 2'b00, 0, 1, 0, 0, 1, 11'b0000000_01_00};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1, 11'b0000000_00_00};
        vecs[3]  = '{0, 0, 9, 9, 0, 9, 9, 2'b00, 0, 1, 0, 0, 1, 11'b0000000_01_01};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 1, 11'b0000000_00_00};
        vecs[5]  = '{0, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 0, 1, 11'b1100010_00_00};
        vecs[6]  = '{7, 0, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 0, 1, 11'b0000110_00_00};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 11'b1111001_00_00};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 1, 11'b0000110_00_00};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1, 11'b0000000_00_00};
        vecs[10] = '{7, 0, 0, 0, 7, 0, 0, 2'b10, 0, 0, 0, 0, 1, 11'b0000000_00_00};
        vecs[11] = '{7, 0, 0, 3, 7, 3, 0, 2'b01, 1, 0, 1, 1, 0, 11'b1111001_00_10};

        // ---- reset state, with inputs that would otherwise stall/flush/forward ----
        v = vecs[11];
        drive(v);
        #12;
        check_outs("reset_outs", 11'd0);
        check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
        check("reset_wait", {31'd0, dut.w_in_wait}, 32'd0);
        check("reset_lwcnt", lw_stall_count, 32'd0);
        check("reset_memcnt", mem_stall_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- table vectors ----
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ---- randomized vectors against the model ----
        for (int i = 0; i < 40; i++) begin
            v = idle();
            v.rs1d = 5'($urandom_range(0, 3)); v.rs2d = 5'($urandom_range(0, 3));
            v.rs1e = 5'($urandom_range(0, 3)); v.rs2e = 5'($urandom_range(0, 3));
            v.rde  = 5'($urandom_range(0, 3)); v.rdm  = 5'($urandom_range(0, 3));
            v.rdw  = 5'($urandom_range(0, 3)); v.rsrc = 2'($urandom_range(0, 3));
            v.rwm  = 1'($urandom_range(0, 1)); v.rww  = 1'($urandom_range(0, 1));
            v.pcsrc = 1'($urandom_range(0, 1)); v.req = 1'($urandom_range(0, 1));
            v.rdy  = 1'($urandom_range(0, 1));
            @(negedge clk);
            drive(v);
            check_outs($sformatf("rand%0d", i), model(v));
        end

        // ---- load-use followed by a clean cycle ----
        drive(idle());
        do_reset();
        v = vecs[5];
        drive(v);
        check_outs("lu_stall", 11'b1100010_00_00);
        @(negedge clk);
        v.rsrc = 2'b00;
        drive(v);
        check_outs("lu_clear", 11'd0);
        check("lu_lwcnt", lw_stall_count, PERF ? 32'd1 : 32'd0);
        check("lu_flushcnt", flush_count, 32'd0);

        // ---- memory wait overriding a branch ----
        drive(idle());
        do_reset();
        v = idle();
        v.pcsrc = 1'b1; v.req = 1'b1; v.rdy = 1'b0;
        drive(v);
        for (int k = 0; k < 3; k++) begin
            check_outs($sformatf("mw_stall%0d", k), 11'b1111001_00_00);
            @(negedge clk);
        end
        check("mw_in_wait", {31'd0, dut.w_in_wait}, 32'd1);
        v.rdy = 1'b1;
        drive(v);
        check_outs("mw_release", 11'b0000110_00_00);
        @(negedge clk);
        check("mw_back_run", {31'd0, dut.w_in_wait}, 32'd0);
        check("mw_memcnt", mem_stall_count, PERF ? 32'd3 : 32'd0);
        check("mw_flushcnt", flush_count, PERF ? 32'd1 : 32'd0);
        check("mw_no_timeout", {31'd0, mem_timeout}, 32'd0);

        // ---- timeout: flag rises after the 4th WAIT cycle and is sticky ----
        drive(idle());
        do_reset();
        v = idle();
        v.req = 1'b1; v.rdy = 1'b0;
        drive(v);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("to_edge%0d", k), {31'd0, mem_timeout}, (k >= 5) ? 32'd1 : 32'd0);
        end
        check_outs("to_still_stall", 11'b1111001_00_00);
        v.rdy = 1'b1;
        drive(v);
        @(negedge clk);
        check("to_sticky", {31'd0, mem_timeout}, 32'd1);
        check("to_run", {31'd0, dut.w_in_wait}, 32'd0);
        check_outs("to_outs_idle", 11'd0);
        rst = 1'b0;
        #1;
        check("to_reset_clear", {31'd0, mem_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- reset asserted mid-wait clears everything without a clock edge ----
        v = vecs[11];
        drive(v);
        @(negedge clk);
        @(negedge clk);
        check("mr_in_wait", {31'd0, dut.w_in_wait}, 32'd1);
        check("mr_memcnt_pre", mem_stall_count, PERF ? 32'd2 : 32'd0);
        rst = 1'b0;
        check_outs("mr_outs", 11'd0);
        check("mr_state", {31'd0, dut.w_in_wait}, 32'd0);
        check("mr_memcnt", mem_stall_count, 32'd0);
        check("mr_flushcnt", flush_count, 32'd0);
        check("mr_timeout", {31'd0, mem_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outs("mr_resume", 11'b1111001_00_10);
        check("mr_resume_wait", {31'd0, dut.w_in_wait}, 32'd1);

        // ---- final report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
